// File: rtl/maclaurin_engine.sv
// Multi-cycle Maclaurin-series evaluator for exp/sin/cos on unsigned Q0.W arguments.
// One shared W x W multiplier; terms are built by multiplying by the argument step and then by a reciprocal LUT.
module maclaurin_engine #(
  parameter int W     = 16,
  parameter int TERMS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   xBus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W+1:0]   rBus
);

  localparam int KW = (TERMS > 2) ? $clog2(TERMS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_MULX,
    S_MULR,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   t_q, t_d;
  logic [W-1:0]   step_q, step_d;
  logic [W+1:0]   acc_q, acc_d;
  logic [KW-1:0]  k_q, k_d;
  logic           err_q, err_d;

  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   prod_hi;
  logic [W-1:0]   lut_sel;

  logic [W-1:0]   lut_exp [TERMS];
  logic [W-1:0]   lut_sin [TERMS];
  logic [W-1:0]   lut_cos [TERMS];

  // floor(2^W / d), clipped to the largest Q0.W value
  function automatic logic [W-1:0] lut_val(input int m, input int kk);
    longint d;
    longint v;
    case (m)
      0:       d = longint'(kk + 1);
      1:       d = longint'((2 * kk + 2) * (2 * kk + 3));
      default: d = longint'((2 * kk + 1) * (2 * kk + 2));
    endcase
    v = (longint'(1) <<< W) / d;
    if (v > (longint'(1) <<< W) - 1) v = (longint'(1) <<< W) - 1;
    return v[W-1:0];
  endfunction

  function automatic logic [W+1:0] sat_add(input logic [W+1:0] a, input logic [W-1:0] b);
    logic [W+2:0] s;
    s = {1'b0, a} + {3'b000, b};
    return s[W+2] ? '1 : s[W+1:0];
  endfunction

  function automatic logic [W+1:0] sat_sub(input logic [W+1:0] a, input logic [W-1:0] b);
    return (a < {2'b00, b}) ? '0 : (a - {2'b00, b});
  endfunction

  for (genvar g = 0; g < TERMS; g++) begin : g_lut
    assign lut_exp[g] = lut_val(0, g);
    assign lut_sin[g] = lut_val(1, g);
    assign lut_cos[g] = lut_val(2, g);
  end

  always_comb begin
    case (mode_q)
      2'd0:    lut_sel = lut_exp[k_q];
      2'd1:    lut_sel = lut_sin[k_q];
      default: lut_sel = lut_cos[k_q];
    endcase
  end

  // Operand mux: x*x in LOAD, t*step in MULX, t*lut in MULR
  always_comb begin
    mul_a = t_q;
    mul_b = step_q;
    case (state_q)
      S_LOAD: begin
        mul_a = x_q;
        mul_b = x_q;
      end
      S_MULR: mul_b = lut_sel;
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_hi = prod[2*W-1:W];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    t_d     = t_q;
    step_d  = step_q;
    acc_d   = acc_q;
    k_d     = k_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          x_d     = xBus;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d = '0;
        k_d   = '0;
        err_d = 1'b0;
        if (mode_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          step_d  = (mode_q == 2'd0) ? x_q : prod_hi;
          t_d     = (mode_q == 2'd1) ? x_q : '1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if ((mode_q != 2'd0) && k_q[0]) acc_d = sat_sub(acc_q, t_q);
        else                            acc_d = sat_add(acc_q, t_q);
        state_d = (k_q == K_LAST) ? S_DONE : S_MULX;
      end
      S_MULX: begin
        t_d     = prod_hi;
        state_d = S_MULR;
      end
      S_MULR: begin
        t_d     = prod_hi;
        k_d     = k_q + 1'b1;
        state_d = S_ACC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      x_q     <= '0;
      t_q     <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      t_q     <= t_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;
  assign rBus = acc_q;

endmodule

// File: tb/tb_maclaurin_engine.sv
// Directed and randomized bench for maclaurin_engine (W=16, TERMS=8) against a series-sum reference model.
module tb_maclaurin_engine;

  localparam int W     = 16;
  localparam int TERMS = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  xBus;
  logic          busy;
  logic          done;
  logic          err;
  logic [W+1:0]  rBus;

  int checks;
  int failures;

  maclaurin_engine #(.W(W), .TERMS(TERMS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .xBus  (xBus),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rBus  (rBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint target, input longint tol);
    longint diff;
    diff = (obs > target) ? (obs - target) : (target - obs);
    checks++;
    assert (diff <= tol) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, target, tol);
    end
  endtask

  // Reciprocal coefficient 1/d of the series recurrence, as a truncated Q0.16 value
  function automatic longint ref_coef(input int m, input int k);
    longint d;
    longint v;
    if (m == 0)      d = k + 1;
    else if (m == 1) d = (2 * k + 2) * (2 * k + 3);
    else             d = (2 * k + 1) * (2 * k + 2);
    v = 65536 / d;
    return (v > 65535) ? 65535 : v;
  endfunction

  // Series sum: term_0 = 1 (exp/cos) or x (sin), term_{k+1} = term_k * step * coef(k), alternating for sin/cos
  function automatic longint ref_eval(input int m, input longint x);
    longint step, term, sum;
    if (m == 3) return 0;
    step = (m == 0) ? x : ((x * x) >> 16);
    term = (m == 1) ? x : 65535;
    sum  = 0;
    for (int k = 0; k < TERMS; k++) begin
      if (m != 0 && (k % 2) == 1) sum = (sum - term < 0) ? 0 : sum - term;
      else                        sum = (sum + term > 262143) ? 262143 : sum + term;
      if (k < TERMS - 1) begin
        term = (term * step) >> 16;
        term = (term * ref_coef(m, k)) >> 16;
      end
    end
    return sum;
  endfunction

  task automatic run_op(input int m, input int x, input bit hammer, output longint res);
    int     first_n;
    int     cnt;
    logic   err_at;
    longint expv;
    first_n = -1;
    cnt     = 0;
    err_at  = 1'b0;
    res     = 0;
    expv    = ref_eval(m, longint'(x));
    mode  = 2'(m);
    xBus  = 16'(x);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      start = hammer && (n <= 24);
      if (hammer) begin
        mode = 2'd3;
        xBus = 16'($urandom_range(0, 65535));
      end
      tick;
      if (done === 1'b1) begin
        cnt++;
        if (first_n < 0) first_n = n;
        res    = longint'(rBus);
        err_at = err;
      end
    end
    start = 1'b0;
    chk($sformatf("done_count m=%0d x=%0d", m, x), cnt, 1);
    chk($sformatf("done_edge m=%0d x=%0d", m, x), first_n, (m == 3) ? 1 : 3 * TERMS - 1);
    chk($sformatf("err m=%0d x=%0d", m, x), longint'(err_at), (m == 3) ? 1 : 0);
    chk($sformatf("rBus m=%0d x=%0d", m, x), res, expv);
    chk($sformatf("busy_after m=%0d x=%0d", m, x), longint'(busy), 0);
  endtask

  initial begin
    longint r;
    int     xr;
    int     mr;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    xBus  = '0;

    repeat (3) tick;
    rst = 1'b0;
    repeat (5) tick;
    chk("idle_rBus", longint'(rBus), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_done", longint'(done), 0);
    chk("idle_err",  longint'(err), 0);

    run_op(0, 0, 1'b0, r);
    chk("zero_exp", r, 65535);
    run_op(2, 0, 1'b0, r);
    chk("zero_cos", r, 65535);
    run_op(1, 0, 1'b0, r);
    chk("zero_sin", r, 0);

    run_op(0, 32768, 1'b0, r);
    chk_near("half_exp", r, 108051, 16);
    run_op(2, 32768, 1'b0, r);
    chk_near("half_cos", r, 57512, 16);
    run_op(1, 32768, 1'b0, r);
    chk_near("half_sin", r, 31420, 16);

    run_op(0, 65535, 1'b0, r);
    chk_near("full_exp", r, 178145, 32);

    run_op(3, int'($urandom_range(0, 65535)), 1'b0, r);
    chk("rsv_rBus", r, 0);
    chk("rsv_err_held", longint'(err), 1);
    run_op(0, int'($urandom_range(0, 65535)), 1'b0, r);
    chk("rsv_err_cleared", longint'(err), 0);

    xr = int'($urandom_range(0, 65535));
    run_op(1, xr, 1'b1, r);
    run_op(2, xr, 1'b0, r);

    xr    = int'($urandom_range(1, 65535));
    mode  = 2'd0;
    xBus  = 16'(xr);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    chk("midrst_rBus", longint'(rBus), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_err",  longint'(err), 0);
    rst = 1'b0;
    tick;
    run_op(0, xr, 1'b0, r);

    for (int i = 0; i < 15; i++) begin
      mr = int'($urandom_range(0, 2));
      xr = int'($urandom_range(0, 65535));
      run_op(mr, xr, 1'b0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maclaurin_engine.md
# maclaurin_engine

Parametrised fixed-point Maclaurin-series evaluator that computes exp(x), sin(x) or cos(x) for 0 ≤ x < 1, selected per operation. It succeeds the single-function cosine datapath. Datapath width and term count are generic, a run-time mode select is added, and the controller FSM and start/busy/done handshake are built in. It sits behind the calculator front end, which supplies x and a mode and collects the Q2.W result.

## Interface
- W, 16, fractional width of x, term and LUT values (Q0.W); result is W+2 bits (Q2.W)
- TERMS, 8, number of series terms summed (2..16)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  start request; sampled only in IDLE
- mode  in  2  0 = exp, 1 = sin, 2 = cos, 3 = reserved; sampled with start
- xBus  in  W  argument x, unsigned Q0.W; sampled with start
- busy  out  1  high from the edge accepting start until the edge leaving DONE
- done  out  1  one-cycle pulse; rBus and err valid
- err  out  1  set when mode = 3 was accepted; held until next accepted start
- rBus  out  W+2  accumulator, unsigned Q2.W; held until next accepted start

## Operation
- Reset: state IDLE; acc, t, step, k, busy, done, err all 0; rBus = 0.
- States: IDLE, LOAD, ACC, MULX, MULR, DONE.
- IDLE: start=1 latches mode and x, and moves to LOAD. start while busy is ignored; no queueing.
- LOAD:
  - acc := 0, k := 0, err := 0.
  - step := x for exp; step := (x·x)[2W-1:W] for sin/cos.
  - t := 2^W−1 (≈1.0) for exp/cos; t := x for sin.
  - mode 3 instead sets err := 1, leaves acc = 0 and goes directly to DONE.
- ACC:
  - Term k is subtracted if mode ∈ {sin, cos} and k is odd. Otherwise it is added.
  - Add: acc := min(acc + {00,t}, 2^(W+2)−1).
  - Subtract: acc := max(acc − {00,t}, 0).
  - If k = TERMS−1, go to DONE. Otherwise go to MULX.
- MULX: t := (t·step)[2W-1:W].
- MULR: t := (t·lut(mode,k))[2W-1:W], k := k+1, then go to ACC.
- LUT: lut = floor(2^W / d), clipped to 2^W−1.
  - exp: d = k+1.
  - cos: d = (2k+1)(2k+2).
  - sin: d = (2k+2)(2k+3).
  - Example, W=16, k=0: exp 0xFFFF, cos 0x8000, sin 0x2AAA.
- DONE: done=1 for one cycle, then go to IDLE. rBus = acc continuously.
- Terms that reach 0 are still iterated; latency is fixed.
- rst asserted mid-operation returns the block to reset state immediately. No partial result is retained.

## Timing
- Edge E0 samples start → LOAD.
- E1 → first ACC. First ACC update happens at E2.
- Each further term costs 3 edges (MULX, MULR, ACC). The final ACC update is at edge 3·TERMS−1.
- done is high in the cycle after that edge: TERMS=8 → update at E23, done during cycle 24, IDLE after E24.
- mode 3: done in the cycle after E1.
- busy rises after E0 and falls after the DONE edge.
- start asserted in the done cycle is ignored. The earliest new start is sampled in the IDLE cycle that follows.
- All products are full 2W-bit unsigned, truncated (no rounding). Accumulator arithmetic is saturating, W+2 bits.

## Test plan
- Reset/idle: hold rst, then release with start=0 → rBus=0, busy=0, done=0, err=0 indefinitely. Assert rst at cycle 10 of a run → outputs 0 next cycle, and a fresh start completes normally.
- Zero argument (W=16, TERMS=8): x=0.
  - exp → rBus=0x0FFFF.
  - cos → rBus=0x0FFFF.
  - sin → rBus=0x00000.
  - Each run: done pulses once, in the cycle after the 23rd edge following the start edge.
- Half argument: x=0x8000.
  - exp → rBus within 16 LSB of 108051.
  - cos → within 16 LSB of 57512.
  - sin → within 16 LSB of 31420.
- Near-full argument: x=0xFFFF, exp → rBus within 32 LSB of 178145, no saturation. Sweep random x for all modes against a golden truncating model, bit-exact.
- Handshake: pulse start every cycle during a run → only the first is accepted. Result is unchanged and done pulses once per accepted start. Back-to-back runs yield no stale err.
- Reserved mode: mode=3 → done in the cycle after E1, err=1, rBus=0. The next start with mode=0 clears err.
